crg_seq_ctrl: RTL
=================

# crg_seq_ctrl

Parametrised clock/reset sequencer for the CRG. It runs on the buffered source clock and drives the enable and select inputs of N_CLK BUFGCE/BUFGMUX clock channels, plus each channel's active-low source reset into its reset synchroniser. It adds what the fixed-wiring CRG lacks:
- MMCM lock qualification and lock-loss shutdown.
- Timed reset release after clock enable.
- Glitch-safe select switching: gate, switch, settle, ungate.

## Interface
Parameters:
- N_CLK, 4, number of managed clock channels (>=1)
- LOCK_FILT, 16, consecutive synced-lock cycles required before pll_ok (>=1)
- RST_HOLD, 32, cycles reset stays asserted after a channel's clock is enabled (>=1)
- SW_GAP, 8, cycles spent in each switch phase, gated-before-switch and settle-after-switch (>=1)

Ports:
- clk_src  in  1  free-running controller clock (post-IBUF source clock)
- rst_n_sys  in  1  asynchronous active-low reset
- mmcm_locked  in  1  MMCM lock, asynchronous to clk_src
- req_en  in  N_CLK  per-channel clock enable request, level
- req_sel  in  N_CLK  per-channel mux select request, level
- pll_ok  out  1  qualified lock
- clk_en  out  N_CLK  to BUFGCE CE
- clk_sel  out  N_CLK  to BUFGMUX S
- rst_req_n  out  N_CLK  active-low channel reset, to synchroniser src_arst
- busy  out  N_CLK  channel is mid-sequence

## Operation
Reset values of all outputs: pll_ok=0, clk_en=0, clk_sel=0, rst_req_n=0, busy=0. All outputs are registered.

Lock qualifier:
- mmcm_locked passes through a 2-FF synchroniser to produce lock_s.
- The counter clears whenever lock_s=0 and saturates at LOCK_FILT.
- pll_ok=1 while the count equals LOCK_FILT.
- lock_s=0 clears pll_ok on the same edge.

Channel FSM, one per channel, with states OFF, EN_HOLD, ON, GATE and SWITCH:
- OFF: clk_en=0, rst_req_n=0. Moves to EN_HOLD when pll_ok && req_en; the counter loads RST_HOLD.
- EN_HOLD: clk_en=1, rst_req_n=0, busy=1. Counts down; at 0 moves to ON.
- ON: clk_en=1, rst_req_n=1. If req_sel != clk_sel, moves to GATE and the counter loads SW_GAP.
- GATE: clk_en=0, rst_req_n=1, busy=1. At count 0 moves to SWITCH; clk_sel <= req_sel as sampled on that edge; the counter reloads SW_GAP.
- SWITCH: clk_en=0, busy=1. At count 0 moves to ON.
- Any state with !req_en or !pll_ok moves to OFF on the next edge. This has priority over all other transitions; clk_sel holds its value.
- A req_sel change during GATE is absorbed, because the value is sampled at SWITCH entry. A change during SWITCH starts a fresh switch cycle from ON.
- The counter width is clog2(max(RST_HOLD, SW_GAP)+1).

## Timing
Lock qualification:
- mmcm_locked first sampled high at edge k gives lock_s=1 after edge k+1.
- pll_ok=1 after edge k+1+LOCK_FILT.
- Lock drop: pll_ok falls 2 edges after mmcm_locked is first sampled low.

Channel enable:
- req_en sampled high at edge e, with pll_ok=1, gives clk_en=1 after e and rst_req_n=1 after e+RST_HOLD.

Channel disable:
- req_en sampled low at edge d gives clk_en=0, rst_req_n=0 and busy=0 after d.
- Lock loss drops all channels on the edge after pll_ok falls.

Select switch:
- Mismatch seen in ON at edge s gives clk_en=0 after s.
- clk_sel updates after s+SW_GAP.
- clk_en=1 after s+2·SW_GAP.
- clk_en is never high on the edge where clk_sel changes.

Reset behaviour:
- rst_n_sys low clears all state asynchronously, including mid-sequence.
- Deassertion restarts from OFF with the lock filter cleared.

## Structure
- Package crg_pkg holds the channel state enum (OFF, EN_HOLD, ON, GATE, SWITCH) and the counter-width function.
- Sub-module crg_ch_seq implements one channel FSM and its counter. It is instantiated N_CLK times via generate.
- The top level holds the lock synchroniser and the filter.

## Test plan
- Lock qualification (LOCK_FILT=16): raise mmcm_locked → pll_ok high exactly 18 edges later. A 5-cycle lock glitch before that → pll_ok stays low and the count restarts.
- Enable sequence (RST_HOLD=32): req_en[0]=1 with pll_ok=1 → clk_en[0] high on the next edge, rst_req_n[0] high 32 edges later, busy[0] high for exactly 32 cycles.
- Select switch (SW_GAP=8): toggle req_sel[1] in ON → clk_en[1] low for 16 cycles. clk_sel[1] changes 8 edges in, never while clk_en[1]=1.
- Abort: drop req_en[2] during GATE → OFF next edge, clk_sel[2] unchanged, busy[2]=0.
- Lock loss with all channels ON: drop mmcm_locked → all clk_en and rst_req_n low 3 edges later. Re-lock → channels re-run EN_HOLD.
- Async reset: assert rst_n_sys mid-SWITCH → all outputs are 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/crg_pkg.sv
// Shared types and helpers for the CRG clock/reset sequencer.
package crg_pkg;

  typedef enum logic [2:0] {
    OFF,
    EN_HOLD,
    ON,
    GATE,
    SWITCH
  } ch_state_e;

  // Wide enough to hold the larger of the two phase lengths.
  function automatic int cnt_width(input int rst_hold, input int sw_gap);
    int m;
    m = (rst_hold > sw_gap) ? rst_hold : sw_gap;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/crg_ch_seq.sv
// One clock channel: enable/reset sequencing and glitch-safe select switching.
module crg_ch_seq
  import crg_pkg::*;
#(
  parameter int RST_HOLD = 32,
  parameter int SW_GAP   = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pll_ok_i,
  input  logic req_en_i,
  input  logic req_sel_i,
  output logic clk_en_o,
  output logic clk_sel_o,
  output logic rst_req_n_o,
  output logic busy_o
);

  localparam int CW = cnt_width(RST_HOLD, SW_GAP);
  localparam logic [CW-1:0] RstHoldC = CW'(RST_HOLD);
  localparam logic [CW-1:0] SwGapC   = CW'(SW_GAP);
  localparam logic [CW-1:0] OneC     = CW'(1);

  ch_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sel_q, sel_d;
  logic          clkEn_q, clkEn_d;
  logic          rstReqN_q, rstReqN_d;
  logic          busy_q, busy_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= OFF;
      cnt_q     <= '0;
      sel_q     <= 1'b0;
      clkEn_q   <= 1'b0;
      rstReqN_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      clkEn_q   <= clkEn_d;
      rstReqN_q <= rstReqN_d;
      busy_q    <= busy_d;
    end
  end

  // Loss of request or lock overrides every other transition; select is kept.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    if (!req_en_i || !pll_ok_i) begin
      state_d = OFF;
      cnt_d   = '0;
    end else begin
      case (state_q)
        OFF: begin
          state_d = EN_HOLD;
          cnt_d   = RstHoldC;
        end
        EN_HOLD: begin
          cnt_d = cnt_q - OneC;
          if (cnt_q == OneC) state_d = ON;
        end
        ON: begin
          if (req_sel_i != sel_q) begin
            state_d = GATE;
            cnt_d   = SwGapC;
          end
        end
        GATE: begin
          cnt_d = cnt_q - OneC;
          if (cnt_q == OneC) begin
            state_d = SWITCH;
            cnt_d   = SwGapC;
            sel_d   = req_sel_i;
          end
        end
        SWITCH: begin
          cnt_d = cnt_q - OneC;
          if (cnt_q == OneC) state_d = ON;
        end
        default: state_d = OFF;
      endcase
    end
  end

  // Outputs decode the next state so they register alongside it.
  always_comb begin
    clkEn_d   = 1'b0;
    rstReqN_d = 1'b0;
    busy_d    = 1'b0;
    case (state_d)
      EN_HOLD: begin
        clkEn_d = 1'b1;
        busy_d  = 1'b1;
      end
      ON: begin
        clkEn_d   = 1'b1;
        rstReqN_d = 1'b1;
      end
      GATE, SWITCH: begin
        rstReqN_d = 1'b1;
        busy_d    = 1'b1;
      end
      default: ;
    endcase
  end

  assign clk_en_o    = clkEn_q;
  assign clk_sel_o   = sel_q;
  assign rst_req_n_o = rstReqN_q;
  assign busy_o      = busy_q;

endmodule

// File: rtl/crg_seq_ctrl.sv
// CRG sequencer top: lock synchroniser and filter feeding N_CLK channel sequencers.
module crg_seq_ctrl
  import crg_pkg::*;
#(
  parameter int N_CLK     = 4,
  parameter int LOCK_FILT = 16,
  parameter int RST_HOLD  = 32,
  parameter int SW_GAP    = 8
) (
  input  logic             clk_src,
  input  logic             rst_n_sys,
  input  logic             mmcm_locked,
  input  logic [N_CLK-1:0] req_en,
  input  logic [N_CLK-1:0] req_sel,
  output logic             pll_ok,
  output logic [N_CLK-1:0] clk_en,
  output logic [N_CLK-1:0] clk_sel,
  output logic [N_CLK-1:0] rst_req_n,
  output logic [N_CLK-1:0] busy
);

  localparam int FW = $clog2(LOCK_FILT + 1);
  localparam logic [FW-1:0] FiltMaxC = FW'(LOCK_FILT);
  localparam logic [FW-1:0] FiltOneC = FW'(1);

  logic [1:0]    lockSync_q;
  logic          lockS;
  logic [FW-1:0] filt_q, filt_d;
  logic          pllOk_q, pllOk_d;

  assign lockS = lockSync_q[1];

  always_ff @(posedge clk_src or negedge rst_n_sys) begin
    if (!rst_n_sys) begin
      lockSync_q <= '0;
      filt_q     <= '0;
      pllOk_q    <= 1'b0;
    end else begin
      lockSync_q <= {lockSync_q[0], mmcm_locked};
      filt_q     <= filt_d;
      pllOk_q    <= pllOk_d;
    end
  end

  // Saturating run-length of synced lock; any low sample restarts it.
  always_comb begin
    filt_d = filt_q;
    if (!lockS)                filt_d = '0;
    else if (filt_q != FiltMaxC) filt_d = filt_q + FiltOneC;
    pllOk_d = (filt_d == FiltMaxC);
  end

  assign pll_ok = pllOk_q;

  for (genvar g = 0; g < N_CLK; g++) begin : g_ch
    crg_ch_seq #(
      .RST_HOLD(RST_HOLD),
      .SW_GAP  (SW_GAP)
    ) u_ch (
      .clk_i      (clk_src),
      .rst_ni     (rst_n_sys),
      .pll_ok_i   (pllOk_q),
      .req_en_i   (req_en[g]),
      .req_sel_i  (req_sel[g]),
      .clk_en_o   (clk_en[g]),
      .clk_sel_o  (clk_sel[g]),
      .rst_req_n_o(rst_req_n[g]),
      .busy_o     (busy[g])
    );
  end

endmodule
